// File: rtl/ifetch_unit.sv
// Instruction fetch unit: PC, credit-limited imem requests, in-order {pc, inst} output queue.
// Define IFU_MISALIGN_CHECK_EN to enable the sticky misaligned-redirect fault (fault_o).
module ifetch_unit #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int unsigned     BUF_DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            stall_i,
    output logic            valid_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] inst_o
`ifdef IFU_MISALIGN_CHECK_EN
    ,
    output logic            fault_o
`endif
);
    localparam int unsigned      PTR_W      = $clog2(BUF_DEPTH);
    localparam int unsigned      CNT_W      = $clog2(BUF_DEPTH + 1);
    localparam logic [XLEN-1:0]  NOP        = XLEN'(32'h0000_0013);
    localparam logic [XLEN-1:0]  ALIGN_MASK = ~XLEN'(3);
    localparam logic [CNT_W:0]   DEPTH      = (CNT_W + 1)'(BUF_DEPTH);
    localparam logic [PTR_W-1:0] LAST       = PTR_W'(BUF_DEPTH - 1);

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]  rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] discard_q, discard_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail;
    logic [CNT_W:0]   used, tail_sum;
    logic [XLEN-1:0]  fifo_pc_q   [BUF_DEPTH];
    logic [XLEN-1:0]  fifo_pc_d   [BUF_DEPTH];
    logic [XLEN-1:0]  fifo_inst_q [BUF_DEPTH];
    logic [XLEN-1:0]  fifo_inst_d [BUF_DEPTH];
    logic             pop, push, gnt, fault;

`ifdef IFU_MISALIGN_CHECK_EN
    logic fault_q, fault_d;

    always_comb begin
        fault   = fault_q;
        fault_o = fault_q;
        fault_d = fault_q | (redirect_i & (|redirect_pc_i[1:0]));
    end
`else
    assign fault = 1'b0;
`endif

    always_comb begin
        valid_o = (count_q != '0) && !fault;
        pc_o    = valid_o ? fifo_pc_q[head_q] : '0;
        inst_o  = valid_o ? fifo_inst_q[head_q] : NOP;

        pop  = valid_o && !stall_i;
        push = imem_rvalid_i && (discard_q == '0);
        // Credit check counts the slot freed by this cycle's pop, so a full-rate stream never bubbles.
        used = (CNT_W + 1)'(outstanding_q) + (CNT_W + 1)'(count_q) - (CNT_W + 1)'(pop);
        imem_req_o  = !rst_i && !redirect_i && !fault && (used < DEPTH);
        imem_addr_o = fetch_pc_q;
        gnt         = imem_req_o && imem_gnt_i;

        tail_sum = (CNT_W + 1)'(head_q) + (CNT_W + 1)'(count_q);
        tail     = (tail_sum >= DEPTH) ? PTR_W'(tail_sum - DEPTH) : PTR_W'(tail_sum);

        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        discard_d     = discard_q;
        head_d        = head_q;
        fifo_pc_d     = fifo_pc_q;
        fifo_inst_d   = fifo_inst_q;
        outstanding_d = outstanding_q + CNT_W'(gnt) - CNT_W'(imem_rvalid_i);
        count_d       = count_q + CNT_W'(push) - CNT_W'(pop);

        if (gnt) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        end
        if (imem_rvalid_i && !push) begin
            discard_d = discard_q - CNT_W'(1);
        end
        // Accepted responses are sequential from the last redirect target, so one running pc suffices.
        if (push) begin
            fifo_pc_d[tail]   = rsp_pc_q;
            fifo_inst_d[tail] = imem_rdata_i;
            rsp_pc_d          = rsp_pc_q + XLEN'(4);
        end
        if (pop) begin
            head_d = (head_q == LAST) ? '0 : head_q + PTR_W'(1);
        end

        if (redirect_i) begin
            count_d       = '0;
            head_d        = '0;
            outstanding_d = outstanding_q - CNT_W'(imem_rvalid_i);
            discard_d     = outstanding_d;
            fetch_pc_d    = redirect_pc_i & ALIGN_MASK;
            rsp_pc_d      = redirect_pc_i & ALIGN_MASK;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            head_q        <= '0;
`ifdef IFU_MISALIGN_CHECK_EN
            fault_q       <= 1'b0;
`endif
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            head_q        <= head_d;
`ifdef IFU_MISALIGN_CHECK_EN
            fault_q       <= fault_d;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        fifo_pc_q   <= fifo_pc_d;
        fifo_inst_q <= fifo_inst_d;
    end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch unit: owns the program counter, issues word fetches to instruction memory over a request/grant/response handshake, and buffers returned words in a small in-order queue. It presents `pc_o`/`inst_o` to the decode stage, which registers both every cycle. Control transfers use a redirect port, which flushes in-flight and buffered fetches. When no valid instruction is available, a NOP is presented so decode always sees a harmless instruction.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `BUF_DEPTH`, default 2: output queue depth; also the credit limit on outstanding plus buffered fetches. Legal values are 2 to 4.
- `clk_i` input, 1: the single clock. All logic is rising-edge.
- `rst_i` input, 1: reset, synchronous and active-high.
- `imem_req_o` output, 1: fetch request.
- `imem_addr_o` output, `XLEN`: fetch address, word aligned.
- `imem_gnt_i` input, 1: request accepted when `imem_req_o & imem_gnt_i`.
- `imem_rvalid_i` input, 1: response valid. Responses arrive in order, at least 1 cycle after the grant.
- `imem_rdata_i` input, `XLEN`: response instruction word.
- `redirect_i` input, 1: change of flow (branch/jump/trap).
- `redirect_pc_i` input, `XLEN`: new fetch address.
- `stall_i` input, 1: decode cannot accept this cycle.
- `valid_o` output, 1: `pc_o`/`inst_o` hold a real fetched instruction.
- `pc_o` output, `XLEN`: address of the presented instruction.
- `inst_o` output, `XLEN`: presented instruction. Driven as 32'h0000_0013 (`addi x0,x0,0`) whenever `valid_o`=0.
- `fault_o` output, 1: misaligned redirect fault. Exists only with `IFU_MISALIGN_CHECK_EN`.

## Operation
- State:
  - `fetch_pc`: next address to request.
  - `outstanding`: granted requests not yet answered, 0 to `BUF_DEPTH`.
  - `discard`: responses still to drop after a redirect.
  - Output FIFO of {pc, inst}, `BUF_DEPTH` entries. The head drives `pc_o`/`inst_o`.
- Pop: an entry is consumed when `valid_o & !stall_i`.
- Request: `imem_req_o` = !`redirect_i` & (`outstanding` + `count` − pop) < `BUF_DEPTH` & !fault.
- Grant: on a grant, `fetch_pc` += 4 (wraps modulo 2^`XLEN`), and `outstanding`++.
- Address stability: `imem_addr_o` = `fetch_pc`. Once `imem_req_o` is raised, address and request stay stable until granted. The only exception is `redirect_i`, which withdraws the request.
- Response:
  - Every `imem_rvalid_i` decrements `outstanding`.
  - If `discard`>0, the word is dropped and `discard`--.
  - Otherwise {pc of that request, `imem_rdata_i`} is pushed. The pc comes from a small pc queue or is recomputed from the head pc + 4·position.
- Redirect, which has priority over pop, push and request in the same cycle:
  - FIFO flushed.
  - `discard` ← `outstanding` − `imem_rvalid_i`; a response arriving this cycle is also dropped.
  - `fetch_pc` ← `redirect_pc_i`.
  - No request this cycle.
- Overflow is impossible by the credit rule. Push and pop in the same cycle leave `count` unchanged.
- Reset values:
  - `imem_req_o`=0, `valid_o`=0, `pc_o`=0, `inst_o`=32'h0000_0013, `fault_o`=0.
  - `fetch_pc`=`RESET_PC`; all counters 0.
  - Reset mid-operation abandons all outstanding fetches. The memory is reset with the same `rst_i`.

## Timing
- First cycle after `rst_i` falls: `imem_req_o`=1, `imem_addr_o`=`RESET_PC`.
- Latency with a 1-cycle memory:
  - grant in cycle N
  - `imem_rvalid_i` in N+1
  - `valid_o`=1 with that word in N+2
- Throughput: one instruction per cycle sustained with `BUF_DEPTH`=2, 1-cycle memory, `imem_gnt_i`=1 and `stall_i`=0.
- Redirect asserted in cycle R: request at `redirect_pc_i` in R+1. `valid_o`=0 from R+1 until the new word arrives.
- Under `stall_i`, `pc_o`/`inst_o`/`valid_o` hold unchanged.

## Configuration
- Macro: `IFU_MISALIGN_CHECK_EN`.
- Defined:
  - A redirect with `redirect_pc_i[1:0]`≠0 flushes as normal, then sets `fault_o`=1, which is sticky until reset.
  - While `fault_o`=1, `imem_req_o` stays 0 and `valid_o` stays 0.
- Undefined:
  - `fault_o` is absent.
  - `redirect_pc_i[1:0]` is ignored (forced to 00), and fetch proceeds.

## Test plan
- Reset release, memory granting every cycle with rdata = addr ^ 32'hA5A5_0000, no stall:
  - requests at 0x0, 0x4, 0x8, …
  - `valid_o` rises 2 cycles after the first grant.
  - `pc_o`/`inst_o` step 0x0/0xA5A5_0000, 0x4/0xA5A5_0004, one per cycle.
- `stall_i` held 5 cycles:
  - outputs frozen.
  - `imem_req_o` drops once `outstanding`+`count`=2.
  - No lost or duplicated instruction after release.
- `imem_gnt_i` low 3 cycles: `imem_req_o`=1 with `imem_addr_o` stable at 0x8 until granted.
- Redirect to 0x100 with 2 fetches outstanding:
  - both responses dropped.
  - Next `valid_o` shows `pc_o`=0x100.
  - NOP presented in between.
- Redirect in the same cycle as `imem_rvalid_i` and a pop: the response is dropped, and `discard` = `outstanding`−1.
- With `IFU_MISALIGN_CHECK_EN`: redirect to 0x102 → `fault_o`=1 next cycle, no further requests. Without the macro, fetch proceeds at 0x100.
